// File: rtl/contador_param_if.sv
// Control and result bundle of contador_param: the enable/mode/load inputs and the
// registered count with its boundary flags. Clock and reset stay plain ports.
interface contador_param_if #(
    parameter int WIDTH = 16
);
    logic             ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] salida;
    logic             RCO;
    logic             SAT;

    modport master (
        output ENB,
        output MODO,
        output entrada,
        input  salida,
        input  RCO,
        input  SAT
    );

    modport slave (
        input  ENB,
        input  MODO,
        input  entrada,
        output salida,
        output RCO,
        output SAT
    );
endinterface

// File: rtl/contador_param.sv
// Up / down / step-down counter modulo MAXVAL+1 with clamped synchronous load,
// optional saturation at the boundaries and a registered ripple-carry flag.
module contador_param #(
    parameter int          WIDTH    = 16,
    parameter int unsigned MAXVAL   = 2**WIDTH - 1,
    parameter int unsigned STEP     = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET_L,
    contador_param_if.slave bus
);
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        CLAMP = 2'd2
    } state_t;

    // One guard bit above WIDTH so compares and the modulo fold never overflow.
    localparam int             XW     = WIDTH + 1;
    localparam logic [WIDTH:0] MAX_X  = XW'(MAXVAL);
    localparam logic [WIDTH:0] STEP_X = XW'(STEP);
    localparam logic [WIDTH:0] ONE_X  = XW'(1);
    localparam logic [WIDTH:0] ZERO_X = '0;

    state_t           state_p1;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_p1;
    logic             rco_p1;
    logic             sat;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   nxt_x;
    logic             bnd;
    logic             clamp_evt;

    // Boundary resolution: wrapped value in modulo mode, clamped value in saturate mode.
    function automatic logic [WIDTH:0] fold(input logic [WIDTH:0] wrap_val,
                                            input logic [WIDTH:0] clamp_val);
        return SATURATE ? clamp_val : wrap_val;
    endfunction

    function automatic logic [WIDTH:0] load_clamp(input logic [WIDTH-1:0] value);
        logic [WIDTH:0] v;
        v = {1'b0, value};
        return (v > MAX_X) ? MAX_X : v;
    endfunction

    always_comb begin
        cnt_x = {1'b0, cnt_p1};
        nxt_x = cnt_x;
        bnd   = 1'b0;
        if (bus.ENB) begin
            unique case (bus.MODO)
                2'b00: begin
                    if (cnt_x < MAX_X) nxt_x = cnt_x + ONE_X;
                    else begin
                        bnd   = 1'b1;
                        nxt_x = fold(ZERO_X, MAX_X);
                    end
                end
                2'b01: begin
                    if (cnt_x > ZERO_X) nxt_x = cnt_x - ONE_X;
                    else begin
                        bnd   = 1'b1;
                        nxt_x = fold(MAX_X, ZERO_X);
                    end
                end
                2'b10: begin
                    if (cnt_x >= STEP_X) nxt_x = cnt_x - STEP_X;
                    else begin
                        bnd   = 1'b1;
                        nxt_x = fold(cnt_x + MAX_X + ONE_X - STEP_X, ZERO_X);
                    end
                end
                default: nxt_x = load_clamp(bus.entrada);
            endcase
        end
        clamp_evt = bnd && SATURATE;
    end

    always_comb begin
        state_nxt = state_p1;
        if (!bus.ENB)      state_nxt = HOLD;
        else if (clamp_evt) state_nxt = CLAMP;
        else               state_nxt = RUN;
    end

    always_comb begin
        sat = (state_p1 == CLAMP);
    end

    // ---- stage 1: registered count, carry and control state ----
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) state_p1 <= HOLD;
        else          state_p1 <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt_p1 <= '0;
            rco_p1 <= 1'b0;
        end else begin
            cnt_p1 <= WIDTH'(nxt_x);
            rco_p1 <= bnd;
        end
    end

    assign bus.salida = cnt_p1;
    assign bus.RCO    = rco_p1;
    assign bus.SAT    = sat;
endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench for contador_param: three instances (16-bit default, decade wrap,
// decade saturate) driven by directed steps followed by a short random run.
module tb_contador_param;
    typedef struct {
        int    dut;
        string tag;
        int    s;
        bit    r;
        bit    t;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET_L;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    contador_param_if #(.WIDTH(16)) bus_a ();
    contador_param_if #(.WIDTH(4))  bus_b ();
    contador_param_if #(.WIDTH(4))  bus_c ();

    contador_param dut_a (.CLK(CLK), .RESET_L(RESET_L), .bus(bus_a));
    contador_param #(.WIDTH(4), .MAXVAL(9), .STEP(3), .SATURATE(1'b0))
        dut_b (.CLK(CLK), .RESET_L(RESET_L), .bus(bus_b));
    contador_param #(.WIDTH(4), .MAXVAL(9), .STEP(3), .SATURATE(1'b1))
        dut_c (.CLK(CLK), .RESET_L(RESET_L), .bus(bus_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic observe(input int d, output logic [31:0] s, output logic [31:0] r,
                           output logic [31:0] t);
        case (d)
            0: begin s = 32'(bus_a.salida); r = 32'(bus_a.RCO); t = 32'(bus_a.SAT); end
            1: begin s = 32'(bus_b.salida); r = 32'(bus_b.RCO); t = 32'(bus_b.SAT); end
            default: begin s = 32'(bus_c.salida); r = 32'(bus_c.RCO); t = 32'(bus_c.SAT); end
        endcase
    endtask

    task automatic check_now(input int d, input string tag, input int s, input bit r, input bit t);
        logic [31:0] os, orr, ot;
        observe(d, os, orr, ot);
        chk({tag, ".salida"}, os, 32'(s));
        chk({tag, ".RCO"}, orr, 32'(r));
        chk({tag, ".SAT"}, ot, 32'(t));
    endtask

    task automatic drive(input int d, input bit enb, input logic [1:0] modo, input logic [15:0] ent);
        case (d)
            0: begin bus_a.ENB = enb; bus_a.MODO = modo; bus_a.entrada = ent; end
            1: begin bus_b.ENB = enb; bus_b.MODO = modo; bus_b.entrada = ent[3:0]; end
            default: begin bus_c.ENB = enb; bus_c.MODO = modo; bus_c.entrada = ent[3:0]; end
        endcase
    endtask

    task automatic push(input int d, input string tag, input int s, input bit r, input bit t);
        exp_t e;
        e.dut = d; e.tag = tag; e.s = s; e.r = r; e.t = t;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_now(e.dut, e.tag, e.s, e.r, e.t);
        end
    endtask

    task automatic op(input int d, input bit enb, input logic [1:0] modo, input logic [15:0] ent,
                      input string tag, input int s, input bit r, input bit t);
        drive(d, enb, modo, ent);
        push(d, tag, s, r, t);
        step();
    endtask

    // Reference behaviour for the MAXVAL=9, STEP=3 instances.
    function automatic void model(input bit satmode, input bit enb, input int modo, input int ent,
                                  inout int cnt, output bit rco, output bit satf);
        int n;
        rco  = 1'b0;
        satf = 1'b0;
        if (!enb) return;
        n = cnt;
        case (modo)
            0: begin
                n = cnt + 1;
                if (n > 9) begin rco = 1'b1; satf = satmode; n = satmode ? 9 : 0; end
            end
            1: begin
                n = cnt - 1;
                if (n < 0) begin rco = 1'b1; satf = satmode; n = satmode ? 0 : 9; end
            end
            2: begin
                n = cnt - 3;
                if (n < 0) begin rco = 1'b1; satf = satmode; n = satmode ? 0 : n + 10; end
            end
            default: n = (ent > 9) ? 9 : ent;
        endcase
        cnt = n;
    endfunction

    initial begin
        int  mb, mc;
        bit  rb, tb, rc, tc, enb;
        int  modo, ent;

        RESET_L = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 2'b00, 16'h0000);
        #12;
        for (int d = 0; d < 3; d++) check_now(d, "reset", 0, 1'b0, 1'b0);
        @(posedge CLK);
        #1 RESET_L = 1'b1;

        // Reset asserted between edges while counting
        op(0, 1'b1, 2'b11, 16'h1233, "a_load", 16'h1233, 1'b0, 1'b0);
        op(0, 1'b1, 2'b00, 16'h0000, "a_count", 16'h1234, 1'b0, 1'b0);
        #3 RESET_L = 1'b0;
        #1;
        check_now(0, "a_async_rst", 0, 1'b0, 1'b0);
        @(posedge CLK);
        #1 RESET_L = 1'b1;
        push(0, "a_after_rst", 1, 1'b0, 1'b0);
        step();

        // Up-wrap at full 16-bit range, then hold
        op(0, 1'b1, 2'b11, 16'hFFFE, "a_ld_fffe", 16'hFFFE, 1'b0, 1'b0);
        op(0, 1'b1, 2'b00, 16'h0000, "a_ffff", 16'hFFFF, 1'b0, 1'b0);
        op(0, 1'b1, 2'b00, 16'h0000, "a_wrap", 16'h0000, 1'b1, 1'b0);
        op(0, 1'b1, 2'b00, 16'h0000, "a_0001", 16'h0001, 1'b0, 1'b0);
        op(0, 1'b0, 2'b00, 16'h0000, "a_hold", 16'h0001, 1'b0, 1'b0);

        // Decade down and step-down modulo 10
        op(1, 1'b1, 2'b11, 16'd1, "b_ld1", 1, 1'b0, 1'b0);
        op(1, 1'b1, 2'b01, 16'd0, "b_dn0", 0, 1'b0, 1'b0);
        op(1, 1'b1, 2'b01, 16'd0, "b_dn9", 9, 1'b1, 1'b0);
        op(1, 1'b1, 2'b01, 16'd0, "b_dn8", 8, 1'b0, 1'b0);
        op(1, 1'b1, 2'b11, 16'd1, "b_ld1b", 1, 1'b0, 1'b0);
        op(1, 1'b1, 2'b10, 16'd0, "b_st8", 8, 1'b1, 1'b0);
        op(1, 1'b1, 2'b10, 16'd0, "b_st5", 5, 1'b0, 1'b0);
        op(1, 1'b1, 2'b10, 16'd0, "b_st2", 2, 1'b0, 1'b0);
        op(1, 1'b1, 2'b10, 16'd0, "b_st9", 9, 1'b1, 1'b0);
        op(1, 1'b1, 2'b00, 16'd0, "b_upwrap", 0, 1'b1, 1'b0);

        // Hold for four edges, then clamped load
        op(1, 1'b1, 2'b11, 16'd5, "b_ld5", 5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) op(1, 1'b0, 2'b00, 16'd0, "b_hold", 5, 1'b0, 1'b0);
        op(1, 1'b1, 2'b11, 16'd12, "b_ld12", 9, 1'b0, 1'b0);

        // Saturation at the top, bottom and on step underflow
        op(2, 1'b1, 2'b11, 16'd8, "c_ld8", 8, 1'b0, 1'b0);
        op(2, 1'b1, 2'b00, 16'd0, "c_up9", 9, 1'b0, 1'b0);
        op(2, 1'b1, 2'b00, 16'd0, "c_clamp1", 9, 1'b1, 1'b1);
        op(2, 1'b1, 2'b00, 16'd0, "c_clamp2", 9, 1'b1, 1'b1);
        op(2, 1'b1, 2'b01, 16'd0, "c_leave", 8, 1'b0, 1'b0);
        op(2, 1'b1, 2'b11, 16'd2, "c_ld2", 2, 1'b0, 1'b0);
        op(2, 1'b1, 2'b10, 16'd0, "c_stclamp", 0, 1'b1, 1'b1);
        op(2, 1'b1, 2'b10, 16'd0, "c_stclamp2", 0, 1'b1, 1'b1);
        op(2, 1'b1, 2'b00, 16'd0, "c_up1", 1, 1'b0, 1'b0);
        op(2, 1'b1, 2'b01, 16'd0, "c_dn0", 0, 1'b0, 1'b0);
        op(2, 1'b1, 2'b01, 16'd0, "c_dnclamp", 0, 1'b1, 1'b1);
        op(2, 1'b0, 2'b01, 16'd0, "c_holdclr", 0, 1'b0, 1'b0);
        op(2, 1'b1, 2'b01, 16'd0, "c_dnclamp2", 0, 1'b1, 1'b1);
        op(2, 1'b1, 2'b11, 16'd3, "c_ldexit", 3, 1'b0, 1'b0);
        op(2, 1'b1, 2'b11, 16'd15, "c_ld15", 9, 1'b0, 1'b0);

        // Random mixed operation on both decade instances against the model
        drive(1, 1'b1, 2'b11, 16'd0);
        drive(2, 1'b1, 2'b11, 16'd0);
        push(1, "b_rnd_init", 0, 1'b0, 1'b0);
        push(2, "c_rnd_init", 0, 1'b0, 1'b0);
        step();
        mb = 0;
        mc = 0;
        for (int i = 0; i < 80; i++) begin
            enb  = ($urandom_range(0, 7) != 0);
            modo = int'($urandom_range(0, 3));
            ent  = int'($urandom_range(0, 15));
            drive(1, enb, 2'(modo), 16'(ent));
            model(1'b0, enb, modo, ent, mb, rb, tb);
            push(1, "b_rnd", mb, rb, tb);
            enb  = ($urandom_range(0, 7) != 0);
            modo = int'($urandom_range(0, 3));
            ent  = int'($urandom_range(0, 15));
            drive(2, enb, 2'(modo), 16'(ent));
            model(1'b1, enb, modo, ent, mc, rc, tc);
            push(2, "c_rnd", mc, rc, tc);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
